// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 5;

    localparam logic [REG_W-1:0] X0 = 5'd0;

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Pipeline register enables, MSB first: pc, if/id write, if/id flush, id/ex flush, ex/mem write.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_write;
    } ctrl_t;

    // Values the enables take while reset is held.
    localparam ctrl_t CTRL_RESET = ctrl_t'(5'b00110);

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the load in EX and the operands read in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    output logic             o_lu_c
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    // x0 is never written, so a load targeting it cannot create a dependency.
    always_comb begin
        w_hit_rs1 = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
        w_hit_rs2 = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
        o_lu_c    = i_ex_mem_read && (i_ex_rd != X0) && (w_hit_rs1 || w_hit_rs2);
    end

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with saturating event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             imem_valid,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic [CNT_W-1:0] cnt_lu_stall,
    output logic [CNT_W-1:0] cnt_mem_freeze,
    output logic [CNT_W-1:0] cnt_redirect
);

    state_t            r_state;
    state_t            w_state_nxt;
    ctrl_t             w_ctrl;
    logic              w_lu;
    logic              w_inc_lu;
    logic              w_inc_frz;
    logic              w_inc_rdr;
    logic [CNT_W-1:0]  r_cnt_lu;
    logic [CNT_W-1:0]  r_cnt_frz;
    logic [CNT_W-1:0]  r_cnt_rdr;

    load_use_detect u_lu (
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rd       (ex_rd),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_lu_c        (w_lu)
    );

    // State register; reset parks the front end waiting for the first fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REFILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority decode: freeze, redirect, refill, load-use, fetch wait, normal advance.
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '0;
        w_inc_lu    = 1'b0;
        w_inc_frz   = 1'b0;
        w_inc_rdr   = 1'b0;
        if (!rst_n) begin
            w_ctrl = CTRL_RESET;
        end else if (dmem_busy) begin
            w_inc_frz = 1'b1;
        end else if (ex_redirect) begin
            w_ctrl.pc_write     = 1'b1;
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.id_ex_flush  = 1'b1;
            w_ctrl.ex_mem_write = 1'b1;
            w_state_nxt         = REFILL;
            w_inc_rdr           = 1'b1;
        end else if (r_state == REFILL) begin
            w_ctrl.ex_mem_write = 1'b1;
            if (imem_valid) begin
                w_ctrl.pc_write    = 1'b1;
                w_ctrl.if_id_write = 1'b1;
                w_state_nxt        = RUN;
            end else begin
                w_ctrl.if_id_flush = 1'b1;
            end
        end else if (w_lu) begin
            w_ctrl.id_ex_flush  = 1'b1;
            w_ctrl.ex_mem_write = 1'b1;
            w_inc_lu            = 1'b1;
        end else if (!imem_valid) begin
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.ex_mem_write = 1'b1;
        end else begin
            w_ctrl.pc_write     = 1'b1;
            w_ctrl.if_id_write  = 1'b1;
            w_ctrl.ex_mem_write = 1'b1;
        end
    end

    // Saturating event counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_lu  <= '0;
            r_cnt_frz <= '0;
            r_cnt_rdr <= '0;
        end else if (cnt_clr) begin
            r_cnt_lu  <= '0;
            r_cnt_frz <= '0;
            r_cnt_rdr <= '0;
        end else begin
            if (w_inc_lu && !(&r_cnt_lu)) begin
                r_cnt_lu <= r_cnt_lu + CNT_W'(1);
            end
            if (w_inc_frz && !(&r_cnt_frz)) begin
                r_cnt_frz <= r_cnt_frz + CNT_W'(1);
            end
            if (w_inc_rdr && !(&r_cnt_rdr)) begin
                r_cnt_rdr <= r_cnt_rdr + CNT_W'(1);
            end
        end
    end

    assign pc_write       = w_ctrl.pc_write;
    assign if_id_write    = w_ctrl.if_id_write;
    assign if_id_flush    = w_ctrl.if_id_flush;
    assign id_ex_flush    = w_ctrl.id_ex_flush;
    assign ex_mem_write   = w_ctrl.ex_mem_write;
    assign cnt_lu_stall   = r_cnt_lu;
    assign cnt_mem_freeze = r_cnt_frz;
    assign cnt_redirect   = r_cnt_rdr;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with small counters to reach saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Expected enable patterns {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}.
    localparam logic [4:0] C_RST  = 5'b00110;
    localparam logic [4:0] C_WAIT = 5'b00101;
    localparam logic [4:0] C_GO   = 5'b11001;
    localparam logic [4:0] C_LU   = 5'b00011;
    localparam logic [4:0] C_RDR  = 5'b10111;
    localparam logic [4:0] C_FRZ  = 5'b00000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic             ex_redirect, imem_valid, dmem_busy, cnt_clr;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write;
    logic [CNT_W-1:0] cnt_lu_stall, cnt_mem_freeze, cnt_redirect;
    logic [4:0]       ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_redirect    (ex_redirect),
        .imem_valid     (imem_valid),
        .dmem_busy      (dmem_busy),
        .cnt_clr        (cnt_clr),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_write   (ex_mem_write),
        .cnt_lu_stall   (cnt_lu_stall),
        .cnt_mem_freeze (cnt_mem_freeze),
        .cnt_redirect   (cnt_redirect)
    );

    assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs are set just after an edge; check enables mid-cycle, then advance one cycle.
    task automatic step(input string tag, input logic [4:0] exp);
        #3;
        check(tag, 32'(ctrl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int lu, input int frz, input int rdr);
        check({tag, "_cnt_lu"},  32'(cnt_lu_stall),   32'(lu));
        check({tag, "_cnt_frz"}, 32'(cnt_mem_freeze), 32'(frz));
        check({tag, "_cnt_rdr"}, 32'(cnt_redirect),   32'(rdr));
    endtask

    task automatic set_lu(input logic rd, input logic [4:0] rdi, input logic [4:0] r1,
                          input logic u1, input logic [4:0] r2, input logic u2);
        ex_mem_read = rd;  ex_rd = rdi;
        id_rs1 = r1; id_uses_rs1 = u1;
        id_rs2 = r2; id_uses_rs2 = u2;
    endtask

    initial begin
        rst_n = 1'b0;
        set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        ex_redirect = 1'b0; imem_valid = 1'b0; dmem_busy = 1'b0; cnt_clr = 1'b0;

        #2;
        check("reset_ctrl", 32'(ctrl), 32'(C_RST));
        check_cnt("reset", 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fetch wait after reset, then first valid fetch enters RUN.
        for (int i = 0; i < 3; i++) step("boot_wait", C_WAIT);
        imem_valid = 1'b1;
        step("boot_fetch", C_GO);

        // Load-use on rs1 (also proves state RUN).
        set_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("lu_rs1", C_LU);
        check_cnt("lu_rs1", 1, 0, 0);
        ex_mem_read = 1'b0;
        step("lu_clear", C_GO);
        set_lu(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step("lu_x0", C_GO);
        set_lu(1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1);
        step("lu_rs2", C_LU);
        set_lu(1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b0);
        step("lu_unused", C_GO);
        check_cnt("lu_misc", 2, 0, 0);
        set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        imem_valid = 1'b0;
        step("run_fetch_wait", C_WAIT);
        imem_valid = 1'b1;
        step("run_resume", C_GO);

        // Redirect with 2-cycle fetch latency.
        ex_redirect = 1'b1;
        step("rdr", C_RDR);
        check_cnt("rdr", 2, 0, 1);
        ex_redirect = 1'b0; imem_valid = 1'b0;
        step("rdr_wait1", C_WAIT);
        step("rdr_wait2", C_WAIT);
        imem_valid = 1'b1;
        step("rdr_fetch", C_GO);

        // Redirect during refill restarts it.
        ex_redirect = 1'b1;
        step("rdr_a", C_RDR);
        ex_redirect = 1'b0; imem_valid = 1'b0;
        step("rdr_a_wait", C_WAIT);
        ex_redirect = 1'b1;
        step("rdr_in_refill", C_RDR);
        ex_redirect = 1'b0; imem_valid = 1'b1;
        step("rdr_b_fetch", C_GO);
        check_cnt("rdr_twice", 2, 0, 3);

        // Freeze over a load-use, stall happens once on release.
        set_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) step("frz_lu", C_FRZ);
        check_cnt("frz_lu", 2, 4, 3);
        dmem_busy = 1'b0;
        step("frz_release_lu", C_LU);
        check_cnt("frz_release", 3, 4, 3);
        ex_mem_read = 1'b0;
        step("frz_after", C_GO);

        // Freeze over a redirect, redirect happens on release.
        dmem_busy = 1'b1; ex_redirect = 1'b1;
        step("frz_rdr", C_FRZ);
        check_cnt("frz_rdr", 3, 5, 3);
        dmem_busy = 1'b0;
        step("frz_release_rdr", C_RDR);
        ex_redirect = 1'b0;
        step("frz_rdr_fetch", C_GO);
        check_cnt("frz_rdr_done", 3, 5, 4);

        // Saturation at 15 with CNT_W=4, then clear beats increment.
        dmem_busy = 1'b1;
        for (int i = 0; i < 12; i++) step("sat_frz", C_FRZ);
        check("sat_hold", 32'(cnt_mem_freeze), 32'd15);
        cnt_clr = 1'b1;
        step("clr_frz", C_FRZ);
        check_cnt("clr", 0, 0, 0);
        cnt_clr = 1'b0;
        step("post_clr", C_FRZ);
        check("post_clr_frz", 32'(cnt_mem_freeze), 32'd1);
        dmem_busy = 1'b0;

        // Asynchronous reset mid-refill.
        ex_redirect = 1'b1;
        step("pre_arst_rdr", C_RDR);
        check("pre_arst_cnt", 32'(cnt_redirect), 32'd1);
        ex_redirect = 1'b0; imem_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", 32'(ctrl), 32'(C_RST));
        check_cnt("arst", 0, 0, 0);
        imem_valid = 1'b1;
        #1;
        check("arst_hold_ctrl", 32'(ctrl), 32'(C_RST));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // In REFILL the load-use is ignored and the fetch is taken.
        set_lu(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        step("arst_refill_fetch", C_GO);
        step("arst_run_lu", C_LU);
        check_cnt("arst_end", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. Each cycle it decides whether the PC, IF/ID, ID/EX and EX/MEM registers advance, hold or are flushed. It handles load-use hazards, EX-stage redirects (taken branch or jump), instruction-fetch wait and data-memory wait. It sits beside the datapath and drives the `pc_write`, `if_id_write`/`if_id_flush`, `id_ex_flush` and `ex_mem_write` enables, and it keeps saturating performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_rs1`, `id_rs2`  in  5  source register indices of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  ID instruction actually reads rs1/rs2.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_redirect`  in  1  EX resolved a taken branch or jump; PC mux selects the target.
- `imem_valid`  in  1  fetch data at the current PC is valid this cycle.
- `dmem_busy`  in  1  MEM-stage access not yet complete.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `pc_write`  out  1  PC loads its next value.
- `if_id_write`  out  1  IF/ID captures the fetched instruction.
- `if_id_flush`  out  1  IF/ID loads a bubble (all-zero).
- `id_ex_flush`  out  1  ID/EX loads a bubble.
- `ex_mem_write`  out  1  EX/MEM and later registers advance.
- `cnt_lu_stall`, `cnt_mem_freeze`, `cnt_redirect`  out  CNT_W  load-use stall cycles, dmem freeze cycles, redirect events.

## Operation
- The FSM has two states: `RUN` and `REFILL`. Outputs are combinational from state plus inputs, so hazards act in the same cycle.
- Load-use condition `lu`: `ex_mem_read` && `ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
- Evaluate in priority order; the first match wins in either state:
  1. `dmem_busy`=1: freeze. All enables 0, no flushes, state unchanged. `cnt_mem_freeze`+1.
  2. `ex_redirect`=1: `pc_write`=1, `if_id_flush`=1, `id_ex_flush`=1, `ex_mem_write`=1. Next state is `REFILL`. `cnt_redirect`+1.
  3. State `REFILL`:
     - `imem_valid`=0: `pc_write`=0, `if_id_flush`=1, `ex_mem_write`=1.
     - `imem_valid`=1: `pc_write`=1, `if_id_write`=1, `ex_mem_write`=1, next state `RUN`.
  4. State `RUN` with `lu`=1: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `ex_mem_write`=1. `cnt_lu_stall`+1.
  5. State `RUN` with `imem_valid`=0: `pc_write`=0, `if_id_flush`=1, `ex_mem_write`=1.
  6. Otherwise: `pc_write`=`if_id_write`=`ex_mem_write`=1, no flushes.
- Outputs not listed for a case are 0.
- `if_id_flush` and `if_id_write` are never both 1.
- Counters saturate at all-ones. `cnt_clr` overrides any increment in the same cycle.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state goes to `REFILL`, counters go to 0;
  - while reset is asserted, outputs are forced: `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_flush`=1, `ex_mem_write`=0.
- After reset release, the first cycle with `imem_valid`=1 latches the instruction and enters `RUN`.
- Load-use costs exactly 1 bubble: the load leaves EX on the next edge, so `lu` drops.
- A redirect costs 2 bubbles plus (cycles until `imem_valid`).
- A redirect during `REFILL` restarts the refill.
- A reset mid-refill or mid-freeze discards the pending state.
- `dmem_busy` together with `ex_redirect` or `lu`: the freeze wins, and the redirect or stall is re-evaluated when the freeze ends (its inputs are held).

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (`RUN`, `REFILL`);
  - a packed struct bundling the five control outputs;
  - localparam `X0`=5'd0.
- Sub-module `load_use_detect` is the combinational `lu` comparator, reusable by a forwarding unit.

## Test plan
- Reset and fetch: hold `rst_n`=0, release with `imem_valid`=0 for 3 cycles, then 1 -> `if_id_flush`=1 for 3 cycles; `if_id_write`=`pc_write`=1 in the 4th; state `RUN`.
- Load-use stall: load writing x5 in EX, ID reads rs1=x5 with `id_uses_rs1`=1 -> one cycle of `pc_write`=0, `id_ex_flush`=1; `cnt_lu_stall`=1. Same case with `ex_rd`=x0 -> no stall.
- Redirect with 2-cycle fetch latency: `ex_redirect`=1 -> both flushes and `pc_write`=1; next 2 cycles `if_id_flush`=1; `cnt_redirect`=1.
- Freeze: `dmem_busy`=1 for 4 cycles while `lu`=1 -> all enables 0 and `cnt_mem_freeze`=4; on release the `lu` stall occurs once.
- Counters: force 2^CNT_W increments with small CNT_W=4 -> the counter holds at 15; `cnt_clr` asserted together with an increment -> 0.
- Asynchronous reset asserted mid-`REFILL` -> outputs take reset values immediately; state `REFILL`, counters 0.
